// File: rtl/fir_coeff_loader_pkg.sv
// fir_pkg: shared definitions for the FIR coefficient loader slice.
//   - data/address widths of the FIR coefficient RAM port
//   - default timing constants (12 MHz clock, 600 kHz sample tick)
//   - loader state encoding
//   - count_legal(): range check applied to a requested coefficient count
package fir_pkg;

  localparam int COEFF_W = 16;
  localparam int ADDR_W  = 6;

  localparam int DEF_MAX_COEFF  = 17;
  localparam int DEF_SAMPLE_DIV = 20;
  localparam int DEF_WR_HOLD    = 2;
  localparam int DEF_GUARD      = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_WAIT_DATA,
    ST_WRITE,
    ST_RELEASE
  } state_t;

  // A coefficient count is usable when it is non-zero and within the
  // symmetric filter's unique-coefficient capacity.
  function automatic logic count_legal(input logic [ADDR_W-1:0] n,
                                       input logic [ADDR_W-1:0] max_n);
    return (n != '0) && (n <= max_n);
  endfunction

endpackage

// File: rtl/fir_coeff_loader_if.sv
// fir_coeff_loader_if: bundles the host request, the upstream coefficient
// stream and the FIR-side update signals of the coefficient loader.
//   slave  : the loader (takes requests and coefficients, drives the FIR)
//   master : the host / testbench side
// Members:
//   iStart, iNumCoeff            load request and coefficient count
//   iCoeffValid, iCoeffData      upstream coefficient stream
//   oCoeffReady                  stream ready back to upstream
//   oCoeffUpdateFlag, oAddrRam,
//   oWrDtRam, oNumOfCoeff        FIR coefficient-update port
//   oEnSample600k                sample-enable tick to the FIR
//   oBusy, oDone, oErr           loader status
interface fir_coeff_loader_if;
  import fir_pkg::*;

  logic               iStart;
  logic [ADDR_W-1:0]  iNumCoeff;
  logic               iCoeffValid;
  logic [COEFF_W-1:0] iCoeffData;
  logic               oCoeffReady;
  logic               oCoeffUpdateFlag;
  logic [ADDR_W-1:0]  oAddrRam;
  logic [COEFF_W-1:0] oWrDtRam;
  logic [ADDR_W-1:0]  oNumOfCoeff;
  logic               oEnSample600k;
  logic               oBusy;
  logic               oDone;
  logic               oErr;

  modport slave (
    input  iStart, iNumCoeff, iCoeffValid, iCoeffData,
    output oCoeffReady, oCoeffUpdateFlag, oAddrRam, oWrDtRam, oNumOfCoeff,
           oEnSample600k, oBusy, oDone, oErr
  );

  modport master (
    output iStart, iNumCoeff, iCoeffValid, iCoeffData,
    input  oCoeffReady, oCoeffUpdateFlag, oAddrRam, oWrDtRam, oNumOfCoeff,
           oEnSample600k, oBusy, oDone, oErr
  );

endinterface

// File: rtl/fir_coeff_loader_sample_tick_gen.sv
// sample_tick_gen: free-running modulo-DIV counter producing a one-cycle
// tick on the last count. The gate only masks the tick; the counter keeps
// running so the tick phase survives periods where the gate is low.
// Ports:
//   clk   system clock
//   rst   synchronous active-high reset (counter to 0)
//   gate  tick enable
//   tick  one-cycle pulse every DIV cycles while gate is high
module sample_tick_gen
  import fir_pkg::*;
#(
  parameter int DIV = DEF_SAMPLE_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic gate,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  // Wraps at DIV-1; never restarted by anything but reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = gate && (count == LAST);

endmodule

// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader: host-side initiator for the FIR coefficient update.
// On an accepted start it raises the update flag, waits GUARD cycles, then
// takes one coefficient per stream handshake and presents it with its RAM
// address for WR_HOLD cycles. After the last coefficient the flag drops,
// and after another GUARD cycles the load is reported done. The 600 kHz
// sample tick is suppressed whenever the loader is not idle.
// Ports:
//   iClk12M  12 MHz system clock
//   iRst     synchronous active-high reset
//   bus      fir_coeff_loader_if.slave (request, stream, FIR port, status)
module fir_coeff_loader
  import fir_pkg::*;
#(
  parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
  parameter int MAX_COEFF  = DEF_MAX_COEFF,
  parameter int WR_HOLD    = DEF_WR_HOLD,
  parameter int GUARD      = DEF_GUARD
) (
  input logic iClk12M,
  input logic iRst,
  fir_coeff_loader_if.slave bus
);

  localparam int TIMER_W = 8;
  localparam logic [TIMER_W-1:0] GUARD_LAST = TIMER_W'(GUARD - 1);
  localparam logic [TIMER_W-1:0] HOLD_LAST  = TIMER_W'(WR_HOLD - 1);
  localparam logic [ADDR_W-1:0]  MAX_N      = ADDR_W'(MAX_COEFF);

  state_t               state, state_next;
  logic [TIMER_W-1:0]   timer, timer_next;
  logic [ADDR_W-1:0]    idx, idx_next;
  logic [ADDR_W-1:0]    addr, addr_next;
  logic [COEFF_W-1:0]   data, data_next;
  logic [ADDR_W-1:0]    num, num_next;
  logic                 done, done_next;
  logic                 err, err_next;
  logic                 idle;

  // State and datapath registers; all next values come from the FSM below.
  always_ff @(posedge iClk12M) begin
    if (iRst) begin
      state <= ST_IDLE;
      timer <= '0;
      idx   <= '0;
      addr  <= '0;
      data  <= '0;
      num   <= MAX_N;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_next;
      timer <= timer_next;
      idx   <= idx_next;
      addr  <= addr_next;
      data  <= data_next;
      num   <= num_next;
      done  <= done_next;
      err   <= err_next;
    end
  end

  // Next-state logic. The timer is shared by the guard and hold phases and
  // is always zero on entry to a timed state.
  always_comb begin
    state_next = state;
    timer_next = timer;
    idx_next   = idx;
    addr_next  = addr;
    data_next  = data;
    num_next   = num;
    done_next  = 1'b0;
    err_next   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (bus.iStart) begin
          if (count_legal(bus.iNumCoeff, MAX_N)) begin
            num_next   = bus.iNumCoeff;
            timer_next = '0;
            state_next = ST_SETUP;
          end else begin
            err_next = 1'b1;
          end
        end
      end

      ST_SETUP: begin
        if (timer == GUARD_LAST) begin
          timer_next = '0;
          idx_next   = '0;
          state_next = ST_WAIT_DATA;
        end else begin
          timer_next = timer + 1'b1;
        end
      end

      ST_WAIT_DATA: begin
        if (bus.iCoeffValid) begin
          addr_next  = idx;
          data_next  = bus.iCoeffData;
          timer_next = '0;
          state_next = ST_WRITE;
        end
      end

      ST_WRITE: begin
        if (timer == HOLD_LAST) begin
          timer_next = '0;
          if (idx == num - 1'b1) begin
            state_next = ST_RELEASE;
          end else begin
            idx_next   = idx + 1'b1;
            state_next = ST_WAIT_DATA;
          end
        end else begin
          timer_next = timer + 1'b1;
        end
      end

      ST_RELEASE: begin
        // Address/data stay on the bus through the trailing guard; the
        // address only returns to 0 once the load is finished.
        if (timer == GUARD_LAST) begin
          timer_next = '0;
          addr_next  = '0;
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end else begin
          timer_next = timer + 1'b1;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign idle = (state == ST_IDLE);

  sample_tick_gen #(
    .DIV (SAMPLE_DIV)
  ) u_tick (
    .clk  (iClk12M),
    .rst  (iRst),
    .gate (idle),
    .tick (bus.oEnSample600k)
  );

  // Ready and flag are decoded from state only, so upstream never sees a
  // combinational path from its own valid.
  assign bus.oCoeffReady      = (state == ST_WAIT_DATA);
  assign bus.oCoeffUpdateFlag = (state == ST_SETUP) || (state == ST_WAIT_DATA) ||
                                (state == ST_WRITE);
  assign bus.oBusy            = !idle;
  assign bus.oAddrRam         = addr;
  assign bus.oWrDtRam         = data;
  assign bus.oNumOfCoeff      = num;
  assign bus.oDone            = done;
  assign bus.oErr             = err;

endmodule
